// File: rtl/gpu_pkg.sv
// Shared GPU definitions: framebuffer geometry, slot-owner encoding and the
// default write-starvation limit used by the framebuffer port arbiter.
package gpu_pkg;

  localparam int unsigned FB_ADDR_W            = 16;  // {row[7:0], col[7:0]}
  localparam int unsigned FB_DATA_W            = 8;   // RRGGBB in [5:0]
  localparam int unsigned STARVE_LIMIT_DEFAULT = 64;

  // Who owns the single RAM port in a given cycle.
  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_VGA    = 2'd1,
    OWN_DRAIN  = 2'd2,
    OWN_CPU_RD = 2'd3
  } owner_e;

endpackage

// File: rtl/fb_wbuf.sv
// Single-entry posted write buffer for the CPU draw port.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   push, push_addr/data load an entry (wins over pop when both are set)
//   pop                  entry is written to RAM this cycle
//   full                 buffer holds an entry
//   buf_addr, buf_data   buffered entry
module fb_wbuf
  import gpu_pkg::*;
#(
  parameter int unsigned ADDR_W = FB_ADDR_W,
  parameter int unsigned DATA_W = FB_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [DATA_W-1:0] buf_data
);

  logic              full_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  // A push in the same cycle as a pop refills the entry, so full stays set.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (push) begin
      full_q <= 1'b1;
      addr_q <= push_addr;
      data_q <= push_data;
    end else if (pop) begin
      full_q <= 1'b0;
    end
  end

  assign full     = full_q;
  assign buf_addr = addr_q;
  assign buf_data = data_q;

endmodule

// File: rtl/fb_port_arbiter.sv
// Framebuffer port arbiter: shares one synchronous-read RAM port between the
// VGA scan-out (absolute priority) and the CPU/GPU draw port (valid/ready).
// CPU writes are posted through fb_wbuf; CPU reads return 2 cycles after the
// handshake with cpu_rvalid.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   vga_req, vga_addr, vga_data     scan-out read; vga_data valid 2 cycles later
//   cpu_valid/we/addr/wdata/ready   draw-port request handshake
//   cpu_rdata, cpu_rvalid           draw-port read return
//   mem_en/we/addr/wdata, mem_rdata RAM port
// Optional feature: define STARVE_GUARD_EN to force a drain after a posted
// write has been blocked by vga_req for STARVE_LIMIT cycles.
module fb_port_arbiter
  import gpu_pkg::*;
#(
  parameter int unsigned ADDR_W       = FB_ADDR_W,
  parameter int unsigned DATA_W       = FB_DATA_W,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_data,
  input  logic              cpu_valid,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  owner_e            owner, owner_q;
  logic              full, drain_now, force_drain;
  logic              rd_pending, rd_ready, rd_hs, wr_hs;
  logic [ADDR_W-1:0] buf_addr, addr_hold_q;
  logic [DATA_W-1:0] buf_data, wdata_hold_q;
  logic [DATA_W-1:0] vga_data_q, cpu_rdata_q;
  logic              cpu_rvalid_q;

`ifdef STARVE_GUARD_EN
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_q;

  assign force_drain = full && vga_req && (starve_q == CNT_W'(STARVE_LIMIT));

  // Counts cycles a buffered write is held off by scan-out.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else if (owner == OWN_DRAIN) begin
      starve_q <= '0;
    end else if (full && vga_req) begin
      starve_q <= starve_q + 1'b1;
    end
  end
`else
  logic [31:0] starve_limit_unused;
  assign starve_limit_unused = 32'(STARVE_LIMIT);
  assign force_drain = 1'b0;
`endif

  // The single read slot is held for the cycle after a CPU read handshake.
  assign rd_pending = (owner_q == OWN_CPU_RD);
  assign drain_now  = full && (force_drain || !vga_req);
  // Reads wait for an empty buffer, which gives read-after-write coherence.
  assign rd_ready   = !vga_req && !full && !rd_pending;
  assign cpu_ready  = cpu_we ? (!full || drain_now) : rd_ready;
  assign rd_hs      = cpu_valid && !cpu_we && rd_ready;
  assign wr_hs      = cpu_valid && cpu_we && cpu_ready;

  always_comb begin
    owner = OWN_NONE;
    if (force_drain)  owner = OWN_DRAIN;
    else if (vga_req) owner = OWN_VGA;
    else if (full)    owner = OWN_DRAIN;
    else if (rd_hs)   owner = OWN_CPU_RD;
  end

  fb_wbuf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wbuf (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_hs),
    .push_addr (cpu_addr),
    .push_data (cpu_wdata),
    .pop       (owner == OWN_DRAIN),
    .full      (full),
    .buf_addr  (buf_addr),
    .buf_data  (buf_data)
  );

  // Idle slots keep address/data stable to avoid needless RAM pin toggling.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr_hold_q;
    mem_wdata = wdata_hold_q;
    unique case (owner)
      OWN_VGA: begin
        mem_en   = 1'b1;
        mem_addr = vga_addr;
      end
      OWN_DRAIN: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = buf_addr;
        mem_wdata = buf_data;
      end
      OWN_CPU_RD: begin
        mem_en   = 1'b1;
        mem_addr = cpu_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q      <= OWN_NONE;
      addr_hold_q  <= '0;
      wdata_hold_q <= '0;
      vga_data_q   <= '0;
      cpu_rdata_q  <= '0;
      cpu_rvalid_q <= 1'b0;
    end else begin
      owner_q      <= owner;
      cpu_rvalid_q <= (owner_q == OWN_CPU_RD);
      if (mem_en) addr_hold_q  <= mem_addr;
      if (mem_we) wdata_hold_q <= mem_wdata;
      if (owner_q == OWN_VGA)    vga_data_q  <= mem_rdata;
      if (owner_q == OWN_CPU_RD) cpu_rdata_q <= mem_rdata;
    end
  end

  assign vga_data   = vga_data_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign cpu_rvalid = cpu_rvalid_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Testbench for fb_port_arbiter: directed scenarios plus a randomized phase.
// Expected read data comes from an architectural shadow memory updated at
// write acceptance; a monitor checks returns against scoreboard queues.
module tb_fb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        vga_req;
  logic [15:0] vga_addr;
  logic [7:0]  vga_data;
  logic        cpu_valid, cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ready;
  logic [7:0]  cpu_rdata;
  logic        cpu_rvalid;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic steal_ok  = 1'b0;
  logic vga_sb_en = 1'b1;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;
  exp_t cpu_q[$];
  exp_t vga_q[$];

  logic [7:0] ram    [65536];
  logic [7:0] shadow [65536];

  fb_port_arbiter #(
    .ADDR_W       (16),
    .DATA_W       (8),
    .STARVE_LIMIT (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vga_req    (vga_req),
    .vga_addr   (vga_addr),
    .vga_data   (vga_data),
    .cpu_valid  (cpu_valid),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ready  (cpu_ready),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] px(input int a);
    if (a == 16'h0102) return 8'h2A;
    if (a == 16'h00FF) return 8'h15;
    return 8'(a * 7 + 3);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Synchronous-read, single-port RAM.
  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = px(i);
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        else        mem_rdata     <= ram[mem_addr];
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    exp_t e;
    for (int i = 0; i < 65536; i++) shadow[i] = px(i);
    forever begin
      @(negedge clk);
      if (rst) begin
        cpu_q.delete();
        vga_q.delete();
      end else begin
        if (cpu_rvalid) begin
          if (cpu_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rvalid_unexpected got=1 want=0 (cycle %0d)", cyc);
          end else begin
            e = cpu_q.pop_front();
            chk("cpu_rdata", cpu_rdata, e.data);
            chk("rd_latency", cyc, e.due);
          end
        end else if (cpu_q.size() != 0 && cpu_q[0].due <= cyc) begin
          e = cpu_q.pop_front();
          chk("cpu_rvalid_missing", cpu_rvalid, 1);
        end
        if (vga_q.size() != 0 && vga_q[0].due == cyc) begin
          e = vga_q.pop_front();
          chk("vga_data", vga_data, e.data);
        end
        if (vga_req && !steal_ok) chk("mem_we_in_vga", mem_we, 0);
        if (vga_req && !cpu_we)   chk("rd_ready_in_vga", cpu_ready, 0);
        if (cpu_valid && cpu_ready) begin
          if (cpu_we) shadow[cpu_addr] = cpu_wdata;
          else cpu_q.push_back('{data: shadow[cpu_addr], due: cyc + 2});
        end
        if (vga_req && vga_sb_en) vga_q.push_back('{data: ram[vga_addr], due: cyc + 2});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   vga_run;
    logic acc;
    rst = 1'b1; vga_req = 1'b0; vga_addr = '0;
    cpu_valid = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_vga_data", vga_data, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_cpu_rvalid", cpu_rvalid, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rd_ready", cpu_ready, 1);

    // VGA only; a CPU read is refused while scan-out owns the port.
    step(); vga_req = 1; vga_addr = 16'h0102; cpu_valid = 1; cpu_we = 0; cpu_addr = 16'h00FF;
    @(negedge clk); chk("vga_blocks_rd", cpu_ready, 0);
    step(); vga_req = 0; cpu_valid = 0;
    step(); @(negedge clk); chk("vga_pixel", vga_data, 8'h2A);

    // CPU read while idle; second read refused while the first is in flight.
    step(); cpu_valid = 1; cpu_we = 0; cpu_addr = 16'h00FF;
    @(negedge clk); chk("rd_idle_ready", cpu_ready, 1);
    step(); @(negedge clk); chk("rd_one_outstanding", cpu_ready, 0);
    step(); cpu_valid = 0;
    @(negedge clk); chk("rd_rvalid", cpu_rvalid, 1); chk("rd_rdata", cpu_rdata, 8'h15);

    // Posted write during the visible region.
    step(); vga_req = 1; vga_addr = 16'h0300;
    cpu_valid = 1; cpu_we = 1; cpu_addr = 16'h1234; cpu_wdata = 8'h3F;
    @(negedge clk); chk("post_ready", cpu_ready, 1); chk("post_no_we0", mem_we, 0);
    step(); cpu_valid = 0; @(negedge clk); chk("post_no_we1", mem_we, 0);
    step(); @(negedge clk); chk("post_no_we2", mem_we, 0);
    step(); vga_req = 0;
    @(negedge clk);
    chk("post_drain_we", mem_we, 1);
    chk("post_drain_addr", mem_addr, 16'h1234);
    chk("post_drain_data", mem_wdata, 8'h3F);

    // Read-after-write: read stalls one cycle behind the drain.
    step(); cpu_valid = 1; cpu_we = 1; cpu_addr = 16'h0010; cpu_wdata = 8'h07;
    @(negedge clk); chk("raw_wr_ready", cpu_ready, 1); chk("raw_no_we", mem_we, 0);
    step(); cpu_we = 0;
    @(negedge clk); chk("raw_rd_stall", cpu_ready, 0); chk("raw_drain", mem_we, 1);
    step(); @(negedge clk); chk("raw_rd_ready", cpu_ready, 1);
    step(); cpu_valid = 0;
    step(); @(negedge clk); chk("raw_rvalid", cpu_rvalid, 1); chk("raw_rdata", cpu_rdata, 8'h07);

    // Back-to-back writes, each draining the following cycle.
    for (int k = 0; k < 3; k++) begin
      step(); cpu_valid = 1; cpu_we = 1;
      cpu_addr = 16'h0020 + 16'(k); cpu_wdata = 8'hA0 + 8'(k);
      @(negedge clk);
      chk("b2b_ready", cpu_ready, 1);
      chk("b2b_we", mem_we, (k != 0));
      if (k != 0) chk("b2b_addr", mem_addr, 16'h0020 + 16'(k - 1));
    end
    step(); cpu_valid = 0;
    @(negedge clk); chk("b2b_last_we", mem_we, 1); chk("b2b_last_addr", mem_addr, 16'h0022);

    // Reset during the cycle after a read handshake.
    step(); cpu_valid = 1; cpu_we = 0; cpu_addr = 16'h0005;
    @(negedge clk); chk("rstrd_ready", cpu_ready, 1);
    step(); cpu_valid = 0; rst = 1;
    step(); rst = 0;
    @(negedge clk);
    chk("rstrd_rvalid", cpu_rvalid, 0);
    chk("rstrd_vga_data", vga_data, 0);
    chk("rstrd_cpu_rdata", cpu_rdata, 0);
    chk("rstrd_mem_en", mem_en, 0);
    chk("rstrd_mem_we", mem_we, 0);
    chk("rstrd_mem_addr", mem_addr, 0);
    chk("rstrd_mem_wdata", mem_wdata, 0);

`ifdef STARVE_GUARD_EN
    // Buffered write blocked by scan-out is forced out after 4 cycles.
    steal_ok = 1; vga_sb_en = 0;
    step(); vga_req = 1; vga_addr = 16'h0200;
    cpu_valid = 1; cpu_we = 1; cpu_addr = 16'h0030; cpu_wdata = 8'h55;
    @(negedge clk); chk("starve_wr_ready", cpu_ready, 1);
    for (int k = 1; k <= 4; k++) begin
      step(); cpu_valid = 0; vga_addr = 16'h0200 + 16'(k);
      @(negedge clk); chk("starve_blocked", mem_we, 0);
    end
    step(); vga_addr = 16'h0205;
    @(negedge clk); chk("starve_force_we", mem_we, 1); chk("starve_force_addr", mem_addr, 16'h0030);
    step(); vga_addr = 16'h0206;
    @(negedge clk); chk("starve_pix", vga_data, px(16'h0204));
    step(); vga_addr = 16'h0207;
    @(negedge clk); chk("starve_pix_repeat", vga_data, px(16'h0204));
    step(); vga_req = 0;
    repeat (3) step();
    steal_ok = 0; vga_sb_en = 1;
`endif

    // Randomized phase; scan-out bursts are short enough that no steal occurs.
    vga_run = 0;
    acc = 1'b0;
    cpu_valid = 0;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (vga_run > 0) begin
        vga_req = 1;
        vga_run--;
      end else begin
        vga_req = 0;
        if ($urandom_range(0, 3) == 0) vga_run = int'($urandom_range(1, 3));
      end
      vga_addr = 16'($urandom);
      if (!(cpu_valid && !acc)) begin
        cpu_valid = ($urandom_range(0, 9) < 6);
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 16'($urandom_range(0, 63));
        cpu_wdata = 8'($urandom);
      end
      @(negedge clk);
      acc = cpu_valid & cpu_ready;
    end

    step(); vga_req = 0; cpu_valid = 0;
    repeat (6) step();
    @(negedge clk);
    for (int a = 0; a < 64; a++) chk("ram_final", ram[a], shadow[a]);
    chk("ram_final_1234", ram[16'h1234], shadow[16'h1234]);
    chk("rd_queue_empty", cpu_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
